sig_src_scheduler: RTL
======================

// Module: sig_src_scheduler
// PURPOSE
//  Time-slot scheduler that shares the 4:1 signal-source mux between four requesting
//  sources. Grants one source at a time, holds it for a programmable slot length, then
//  inserts a muted guard gap before re-arbitrating round-robin. Drives the mux select
//  directly. Sits between the source generators and the output mux.
// PARAMETERS
//  SLOT_W     8   width of slot-length counter / config value
//  DEF_SLOT   16  slot length (cycles) loaded at reset
//  GAP_CYCLES 1   guard-gap length in cycles; legal range 1..15
// PORTS
//  clk          in   1        system clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  en           in   1        scheduler enable
//  req          in   4        per-source request, level
//  done         in   4        per-source early release; sampled only for granted source
//  slot_len_i   in   SLOT_W   new slot length
//  slot_len_we  in   1        write strobe for slot_len_i
//  sel          out  2        mux select (binary index of granted source)
//  sel_vld      out  1        1 = sel is live, output valid
//  gnt          out  4        one-hot grant, all zero when not in HOLD
//  mute         out  1        1 = downstream output must be silenced
// BEHAVIOUR
//  Reset: state=IDLE, sel=0, sel_vld=0, gnt=0, mute=1, slot_len_q=DEF_SLOT, ptr=3.
//  All outputs are registered. States: IDLE, HOLD, GAP.
//  Arbitration (IDLE, or last GAP cycle): if en && |req, winner = first set req bit
//   searching from ptr+1 upward with wrap 3->0. Next cycle: HOLD, gnt=onehot(winner),
//   sel=winner, sel_vld=1, mute=0, ptr=winner, cnt=max(slot_len_q,1)-1.
//   Latency req->gnt = 1 cycle.
//  HOLD: cnt decrements each cycle. Exit to GAP on the cycle after any of: cnt==0,
//   done[sel]=1, req[sel]=0, en=0. A slot with slot_len_q=N lasts exactly N cycles
//   unless released early.
//  GAP: gnt=0, sel_vld=0, mute=1, sel holds last value; lasts GAP_CYCLES cycles. The
//   last GAP cycle arbitrates: winner -> HOLD, else -> IDLE.
//  IDLE: gnt=0, sel_vld=0, mute=1, sel holds.
//  slot_len_we: slot_len_q updated on any cycle; takes effect at the next grant, never
//   mid-slot. Written value 0 is treated as 1.
//  Boundaries: same source re-granted after GAP if it is the only requester. done
//   and req changes for non-granted sources are ignored in HOLD. en low in IDLE keeps
//   IDLE. rst mid-slot forces the reset values immediately.
// CONFIGURATION
//  PRIO0_EN defined: req[0] wins every arbitration regardless of ptr (ptr still
//   updates). req[0] rising during another source's HOLD ends that slot: GAP next cycle.
//  PRIO0_EN undefined: pure round-robin, no preemption; req[0] is ordinary.
// STRUCTURE
//  sig_gen_pkg: state enum {IDLE,HOLD,GAP}, NUM_SRC=4, SEL_W=2, onehot/index helpers.
//  Sub-module rr_pick4: combinational round-robin picker. Inputs: req[3:0], ptr[1:0].
//   Outputs: any, idx[1:0]. Priority-0 override stays in the parent under PRIO0_EN.
// TESTING
//  1 Reset, en=1, req=0010, slot=16 -> gnt=0010 1 cycle later, sel=1 for 16 cycles,
//    then 1 GAP cycle (mute=1), then re-grant of source 1.
//  2 req=1111 held, slot=4 -> grant order 0,1,2,3,0 with 4-cycle slots and 1-cycle gaps.
//  3 Grant src2, pulse done[2] on 3rd slot cycle -> GAP next cycle; done[1] pulse is
//    ignored.
//  4 Write slot_len_i=3 mid-slot -> current slot keeps 16 cycles, next slot is 3 cycles.
//    Write 0 -> slot is 1 cycle.
//  5 en=0 mid-HOLD -> GAP then IDLE; sel_vld=0, mute=1 held. rst mid-HOLD -> reset
//    values at once.
//  6 PRIO0_EN: src3 in HOLD, req[0] rises -> GAP next cycle, then gnt=0001; without
//    PRIO0_EN src3 completes its slot.

Source files
------------

// File: rtl/sig_gen_pkg.sv
// Shared definitions for the signal-source scheduler: source count, select width,
// FSM state encodings and small index helpers.
package sig_gen_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ST_W    = 2;
  localparam int unsigned GAP_W   = 4;

  // Scheduler states
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_HOLD = 2'd1;
  localparam logic [ST_W-1:0] ST_GAP  = 2'd2;

  // One-hot grant vector for a binary source index
  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

  // Source index 'ofs' positions after 'base', wrapping 3 -> 0
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input logic [2:0]       ofs);
    return SEL_W'(base + SEL_W'(ofs));
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set request strictly after ptr,
// wrapping around, with ptr itself considered last.
module rr_pick4
  import sig_gen_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx
);

  logic       found;
  logic [1:0] cand;

  // Scan ptr+1, ptr+2, ptr+3, ptr and keep the first requester seen
  always_comb begin
    any   = |req;
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = wrap_add(ptr, 3'(k));
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sig_src_scheduler.sv
// Time-slot scheduler for the shared 4:1 signal-source mux. Grants one source for a
// programmable slot, then mutes the output for a guard gap before re-arbitrating.
// Optional build macro: PRIO0_EN -- source 0 always wins arbitration and preempts
// any other source's slot while it requests.
module sig_src_scheduler
  import sig_gen_pkg::*;
#(
  parameter int unsigned SLOT_W     = 8,
  parameter int unsigned DEF_SLOT   = 16,
  parameter int unsigned GAP_CYCLES = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        req,
  input  logic [3:0]        done,
  input  logic [SLOT_W-1:0] slot_len_i,
  input  logic              slot_len_we,
  output logic [1:0]        sel,
  output logic              sel_vld,
  output logic [3:0]        gnt,
  output logic              mute
);

  localparam int unsigned DEF_SLOT_SAFE = (DEF_SLOT == 0) ? 1 : DEF_SLOT;

  logic [ST_W-1:0]   state_q, state_d;
  logic [SLOT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        sel_d;
  logic [3:0]        gnt_d;
  logic              sel_vld_d;
  logic              mute_d;
  logic [SLOT_W-1:0] slot_len_q;

  logic              pick_any;
  logic [1:0]        pick_idx;
  logic              arb_go_c;
  logic [1:0]        arb_idx_c;
  logic              release_c;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Arbitration result and slot release condition
  always_comb begin
    arb_go_c  = en && pick_any;
    release_c = (cnt_q == '0) || done[sel_q_idx()] || !req[sel_q_idx()] || !en;
`ifdef PRIO0_EN
    arb_idx_c = req[0] ? 2'd0 : pick_idx;
    if (req[0] && (sel != 2'd0)) begin
      release_c = 1'b1;
    end
`else
    arb_idx_c = pick_idx;
`endif
  end

  function automatic logic [1:0] sel_q_idx();
    return sel;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    ptr_d     = ptr_q;
    sel_d     = sel;
    gnt_d     = '0;
    sel_vld_d = 1'b0;
    mute_d    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (arb_go_c) begin
          state_d   = ST_HOLD;
          gnt_d     = onehot(arb_idx_c);
          sel_d     = arb_idx_c;
          sel_vld_d = 1'b1;
          mute_d    = 1'b0;
          ptr_d     = arb_idx_c;
          cnt_d     = SLOT_W'(slot_len_q - SLOT_W'(1));
        end
      end

      ST_HOLD: begin
        if (release_c) begin
          state_d = ST_GAP;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d     = SLOT_W'(cnt_q - SLOT_W'(1));
          gnt_d     = onehot(sel);
          sel_vld_d = 1'b1;
          mute_d    = 1'b0;
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          if (arb_go_c) begin
            state_d   = ST_HOLD;
            gnt_d     = onehot(arb_idx_c);
            sel_d     = arb_idx_c;
            sel_vld_d = 1'b1;
            mute_d    = 1'b0;
            ptr_d     = arb_idx_c;
            cnt_d     = SLOT_W'(slot_len_q - SLOT_W'(1));
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = GAP_W'(gap_q - GAP_W'(1));
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= 2'd3;
      sel     <= 2'd0;
      gnt     <= '0;
      sel_vld <= 1'b0;
      mute    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      sel     <= sel_d;
      gnt     <= gnt_d;
      sel_vld <= sel_vld_d;
      mute    <= mute_d;
    end
  end

  // Slot-length config; zero is stored as one so a slot is never empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_len_q <= SLOT_W'(DEF_SLOT_SAFE);
    end else if (slot_len_we) begin
      slot_len_q <= (slot_len_i == '0) ? SLOT_W'(1) : slot_len_i;
    end
  end

endmodule
